// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: takes DIGITS packed BCD digits, snapshots them once
// per frame and time-multiplexes them onto a single seven-segment display.
//
// Parameters
//   DIGITS    number of BCD digits scanned (>= 1)
//   SCAN_DIV  clock cycles each digit is held (>= 1)
//
// Ports
//   CLK         system clock, rising-edge active
//   Clear       asynchronous active-high reset
//   Enable      scan enable, sampled on CLK rising edge
//   BCD_in      packed digits, BCD_in[3:0] is digit 0
//   Seg         segment drive {g,f,e,d,c,b,a}, active-high
//   Digit_sel   one-hot digit enable, bit i selects digit i
//   Frame_done  one-cycle pulse on the last cycle of each frame
//
// Optional build macro
//   LZB_EN      leading-zero blanking: digits above the most significant
//               nonzero digit (captured at LOAD) show blank segments.
module bcd_display_scanner #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic                  CLK,
  input  logic                  Clear,
  input  logic                  Enable,
  input  logic [4*DIGITS-1:0]   BCD_in,
  output logic [6:0]            Seg,
  output logic [DIGITS-1:0]     Digit_sel,
  output logic                  Frame_done
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BCD_W-1:0]   snap_q, snap_d;
  logic               last_div, last_idx;
  logic [3:0]         cur_digit;

`ifdef LZB_EN
  logic [IDX_W-1:0]   lz_q, lz_d;
  logic [IDX_W-1:0]   msnz;
`endif

  // Seven-segment decode, gfedcba; codes 10-15 show "E".
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h79;
    endcase
  endfunction

  assign last_div = (div_q == DIV_W'(SCAN_DIV - 1));
  assign last_idx = (idx_q == IDX_W'(DIGITS - 1));

`ifdef LZB_EN
  // Index of the most significant nonzero digit; 0 when all digits are zero,
  // so digit 0 is never blanked. Invalid codes are nonzero by construction.
  always_comb begin
    msnz = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (BCD_in[4*i +: 4] != 4'd0) msnz = IDX_W'(i);
    end
  end
`endif

  // State and datapath registers.
  always_ff @(posedge CLK or posedge Clear) begin
    if (Clear) begin
      state_q <= IDLE;
      idx_q   <= '0;
      div_q   <= '0;
      snap_q  <= '0;
`ifdef LZB_EN
      lz_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      div_q   <= div_d;
      snap_q  <= snap_d;
`ifdef LZB_EN
      lz_q    <= lz_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    div_d   = div_q;
    snap_d  = snap_q;
`ifdef LZB_EN
    lz_d    = lz_q;
`endif
    case (state_q)
      IDLE: begin
        if (Enable) state_d = LOAD;
      end
      LOAD: begin
        snap_d  = BCD_in;
        idx_d   = '0;
        div_d   = '0;
`ifdef LZB_EN
        lz_d    = msnz;
`endif
        state_d = SCAN;
      end
      SCAN: begin
        if (!last_div) begin
          div_d = div_q + DIV_W'(1);
        end else if (!last_idx) begin
          idx_d = idx_q + IDX_W'(1);
          div_d = '0;
        end else begin
          // Frame complete: Enable only matters here, never mid-frame.
          idx_d   = '0;
          div_d   = '0;
          state_d = Enable ? LOAD : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore output decode from registered state only.
  always_comb begin
    Seg        = '0;
    Digit_sel  = '0;
    Frame_done = 1'b0;
    cur_digit  = '0;
    if (state_q == SCAN) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        if (idx_q == IDX_W'(i)) begin
          Digit_sel[i] = 1'b1;
          cur_digit    = snap_q[4*i +: 4];
        end
      end
      Seg = seg_decode(cur_digit);
`ifdef LZB_EN
      if (idx_q > lz_q) Seg = '0;
`endif
      Frame_done = last_div && last_idx;
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed testbench for bcd_display_scanner (DIGITS=4, SCAN_DIV=2), plus a
// DIGITS=1, SCAN_DIV=1 instance for the degenerate case.
module tb_bcd_display_scanner;

  logic        CLK = 1'b0;
  logic        Clear;
  logic        Enable;
  logic [15:0] BCD_in;
  logic [6:0]  Seg;
  logic [3:0]  Digit_sel;
  logic        Frame_done;

  logic        Enable1;
  logic [3:0]  BCD1;
  logic [6:0]  Seg1;
  logic [0:0]  Sel1;
  logic        Fd1;

  int checks = 0;
  int errors = 0;

  bcd_display_scanner #(.DIGITS(4), .SCAN_DIV(2)) dut (
    .CLK(CLK), .Clear(Clear), .Enable(Enable), .BCD_in(BCD_in),
    .Seg(Seg), .Digit_sel(Digit_sel), .Frame_done(Frame_done)
  );

  bcd_display_scanner #(.DIGITS(1), .SCAN_DIV(1)) dut1 (
    .CLK(CLK), .Clear(Clear), .Enable(Enable1), .BCD_in(BCD1),
    .Seg(Seg1), .Digit_sel(Sel1), .Frame_done(Fd1)
  );

  always #5 CLK = ~CLK;

  // Advance one rising edge, then settle 1 time unit before sampling/driving.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    Clear = 1'b1; Enable = 1'b1; BCD_in = 16'h1234;
    Enable1 = 1'b0; BCD1 = 4'h0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (Seg !== 7'h00) begin errors++; $display("FAIL reset_seg cyc %0d got %h want 00", c, Seg); end
      checks++; if (Digit_sel !== 4'b0000) begin errors++; $display("FAIL reset_sel cyc %0d got %b want 0000", c, Digit_sel); end
      checks++; if (Frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd cyc %0d got %b want 0", c, Frame_done); end
    end
  endtask

  task automatic test_normal_scan();
    logic [6:0] exp [4];
    logic [3:0] exp_sel;
    exp[0] = 7'h66; exp[1] = 7'h4F; exp[2] = 7'h5B; exp[3] = 7'h06;
    Clear = 1'b0;
    tick(); // LOAD
    checks++; if (Digit_sel !== 4'b0000 || Seg !== 7'h00) begin errors++; $display("FAIL normal_load got sel %b seg %h want 0000/00", Digit_sel, Seg); end
    for (int c = 0; c < 8; c++) begin
      tick();
      exp_sel = 4'(1 << (c / 2));
      checks++; if (Digit_sel !== exp_sel) begin errors++; $display("FAIL normal_sel cyc %0d got %b want %b", c, Digit_sel, exp_sel); end
      checks++; if (Seg !== exp[c/2]) begin errors++; $display("FAIL normal_seg cyc %0d got %h want %h", c, Seg, exp[c/2]); end
      checks++; if (Frame_done !== (c == 7)) begin errors++; $display("FAIL normal_fd cyc %0d got %b want %b", c, Frame_done, (c == 7)); end
    end
    tick(); // back to LOAD: 9-cycle period
    checks++; if (Digit_sel !== 4'b0000 || Seg !== 7'h00 || Frame_done !== 1'b0) begin errors++; $display("FAIL normal_reload got sel %b seg %h fd %b want 0000/00/0", Digit_sel, Seg, Frame_done); end
  endtask

  task automatic test_snapshot();
    logic [6:0] exp_a [4];
    logic [6:0] exp_b [4];
    logic [3:0] exp_sel;
    exp_a[0] = 7'h66; exp_a[1] = 7'h4F; exp_a[2] = 7'h5B; exp_a[3] = 7'h06;
    exp_b[0] = 7'h7F; exp_b[1] = 7'h07; exp_b[2] = 7'h7D; exp_b[3] = 7'h6D;
    for (int c = 0; c < 8; c++) begin
      tick();
      exp_sel = 4'(1 << (c / 2));
      checks++; if (Digit_sel !== exp_sel || Seg !== exp_a[c/2]) begin errors++; $display("FAIL snap_frame1 cyc %0d got %b/%h want %b/%h", c, Digit_sel, Seg, exp_sel, exp_a[c/2]); end
      if (c == 2) BCD_in = 16'h5678;
    end
    tick();
    checks++; if (Seg !== 7'h00) begin errors++; $display("FAIL snap_load got %h want 00", Seg); end
    for (int c = 0; c < 8; c++) begin
      tick();
      exp_sel = 4'(1 << (c / 2));
      checks++; if (Digit_sel !== exp_sel || Seg !== exp_b[c/2]) begin errors++; $display("FAIL snap_frame2 cyc %0d got %b/%h want %b/%h", c, Digit_sel, Seg, exp_sel, exp_b[c/2]); end
    end
    tick(); // LOAD
  endtask

  task automatic test_invalid();
    logic [6:0] exp [4];
    exp[0] = 7'h6F; exp[1] = 7'h79;
`ifdef LZB_EN
    exp[2] = 7'h00; exp[3] = 7'h00;
`else
    exp[2] = 7'h3F; exp[3] = 7'h3F;
`endif
    BCD_in = 16'h00A9;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++; if (Seg !== exp[c/2]) begin errors++; $display("FAIL invalid_seg cyc %0d got %h want %h", c, Seg, exp[c/2]); end
    end
    tick(); // LOAD
  endtask

  task automatic test_enable_drop();
    logic [6:0] exp [4];
    logic [3:0] exp_sel;
    exp[0] = 7'h66; exp[1] = 7'h4F; exp[2] = 7'h5B; exp[3] = 7'h06;
    BCD_in = 16'h1234;
    for (int c = 0; c < 8; c++) begin
      tick();
      exp_sel = 4'(1 << (c / 2));
      checks++; if (Digit_sel !== exp_sel || Seg !== exp[c/2]) begin errors++; $display("FAIL endrop_scan cyc %0d got %b/%h want %b/%h", c, Digit_sel, Seg, exp_sel, exp[c/2]); end
      checks++; if (Frame_done !== (c == 7)) begin errors++; $display("FAIL endrop_fd cyc %0d got %b want %b", c, Frame_done, (c == 7)); end
      if (c == 2) Enable = 1'b0;
    end
    for (int c = 0; c < 2; c++) begin
      tick(); // IDLE
      checks++; if (Digit_sel !== 4'b0000 || Seg !== 7'h00 || Frame_done !== 1'b0) begin errors++; $display("FAIL endrop_idle cyc %0d got %b/%h/%b want 0000/00/0", c, Digit_sel, Seg, Frame_done); end
    end
  endtask

  task automatic test_clear_mid();
    Enable = 1'b1;
    tick(); // LOAD
    for (int c = 0; c < 5; c++) tick(); // digit 2, first cycle
    checks++; if (Digit_sel !== 4'b0100 || Seg !== 7'h5B) begin errors++; $display("FAIL clrmid_pre got %b/%h want 0100/5B", Digit_sel, Seg); end
    #2 Clear = 1'b1;
    #1;
    checks++; if (Digit_sel !== 4'b0000 || Seg !== 7'h00 || Frame_done !== 1'b0) begin errors++; $display("FAIL clrmid_async got %b/%h/%b want 0000/00/0", Digit_sel, Seg, Frame_done); end
    #2 Clear = 1'b0;
    tick(); // IDLE -> LOAD
    checks++; if (Digit_sel !== 4'b0000 || Seg !== 7'h00) begin errors++; $display("FAIL clrmid_after got %b/%h want 0000/00", Digit_sel, Seg); end
  endtask

  task automatic test_lzb();
    logic [6:0] exp_a [4];
    logic [6:0] exp_b [4];
`ifdef LZB_EN
    exp_a[0] = 7'h3F; exp_a[1] = 7'h6D; exp_a[2] = 7'h00; exp_a[3] = 7'h00;
    exp_b[0] = 7'h3F; exp_b[1] = 7'h00; exp_b[2] = 7'h00; exp_b[3] = 7'h00;
`else
    exp_a[0] = 7'h3F; exp_a[1] = 7'h6D; exp_a[2] = 7'h3F; exp_a[3] = 7'h3F;
    exp_b[0] = 7'h3F; exp_b[1] = 7'h3F; exp_b[2] = 7'h3F; exp_b[3] = 7'h3F;
`endif
    BCD_in = 16'h0050;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++; if (Seg !== exp_a[c/2] || Digit_sel !== 4'(1 << (c / 2))) begin errors++; $display("FAIL lzb_0050 cyc %0d got %b/%h want seg %h", c, Digit_sel, Seg, exp_a[c/2]); end
    end
    tick(); // LOAD
    BCD_in = 16'h0000;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++; if (Seg !== exp_b[c/2] || Digit_sel !== 4'(1 << (c / 2))) begin errors++; $display("FAIL lzb_0000 cyc %0d got %b/%h want seg %h", c, Digit_sel, Seg, exp_b[c/2]); end
    end
  endtask

  task automatic test_single_digit();
    Enable1 = 1'b1; BCD1 = 4'h7;
    tick(); // LOAD
    checks++; if (Sel1 !== 1'b0 || Seg1 !== 7'h00 || Fd1 !== 1'b0) begin errors++; $display("FAIL single_load got %b/%h/%b want 0/00/0", Sel1, Seg1, Fd1); end
    tick(); // SCAN, one cycle frame
    checks++; if (Sel1 !== 1'b1 || Seg1 !== 7'h07 || Fd1 !== 1'b1) begin errors++; $display("FAIL single_scan got %b/%h/%b want 1/07/1", Sel1, Seg1, Fd1); end
    BCD1 = 4'hC;
    tick(); // LOAD again: 2-cycle period
    checks++; if (Sel1 !== 1'b0 || Fd1 !== 1'b0) begin errors++; $display("FAIL single_reload got %b/%b want 0/0", Sel1, Fd1); end
    tick();
    checks++; if (Sel1 !== 1'b1 || Seg1 !== 7'h79 || Fd1 !== 1'b1) begin errors++; $display("FAIL single_invalid got %b/%h/%b want 1/79/1", Sel1, Seg1, Fd1); end
  endtask

  initial begin
    test_reset();
    test_normal_scan();
    test_snapshot();
    test_invalid();
    test_enable_drop();
    test_clear_mid();
    test_lzb();
    test_single_digit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
